// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: MEM-stage core port has priority, and the aux master
// is guaranteed one slot after STARVE_LIMIT consecutive denied cycles.
package dmem_pkg;
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } data_size_e;
endpackage

module dmem_port_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH   = 10,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  core_re_i,
   input  logic                  core_we_i,
   input  data_size_e            core_size_i,
   input  logic [ADDR_WIDTH-1:0] core_addr_i,
   input  logic [31:0]           core_wdata_i,
   output logic [31:0]           core_rdata_o,
   output logic                  core_stall_o,
   input  logic                  aux_valid_i,
   input  logic                  aux_we_i,
   input  data_size_e            aux_size_i,
   input  logic [ADDR_WIDTH-1:0] aux_addr_i,
   input  logic [31:0]           aux_wdata_i,
   output logic                  aux_ready_o,
   output logic                  aux_rvalid_o,
   output logic [31:0]           aux_rdata_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_re_o,
   output logic                  mem_we_o,
   output data_size_e            mem_size_o,
   output logic [31:0]           mem_wdata_o,
   input  logic [31:0]           mem_rdata_i
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_r;
   logic             core_req_s;
   logic             aux_win_s;
   logic             aux_rd_xfer_s;
   logic             aux_rvalid_r;
   logic [31:0]      aux_rdata_r;

   // Request decode and aux win; nothing is granted while reset is held.
   always_comb begin
      core_req_s    = core_re_i | core_we_i;
      aux_win_s     = !rst & aux_valid_i & (!core_req_s | (starve_cnt_r == CNT_MAX));
      aux_rd_xfer_s = aux_win_s & !aux_we_i;
   end

   // Memory-port mux and handshake outputs.
   always_comb begin
      mem_addr_o   = core_addr_i;
      mem_size_o   = core_size_i;
      mem_wdata_o  = core_wdata_i;
      mem_re_o     = 1'b0;
      mem_we_o     = 1'b0;
      aux_ready_o  = 1'b0;
      core_stall_o = 1'b0;
      if (rst) begin
         mem_re_o     = 1'b0;
         mem_we_o     = 1'b0;
      end else if (aux_win_s) begin
         mem_addr_o   = aux_addr_i;
         mem_size_o   = aux_size_i;
         mem_wdata_o  = aux_wdata_i;
         mem_re_o     = !aux_we_i;
         mem_we_o     = aux_we_i;
         aux_ready_o  = 1'b1;
         core_stall_o = core_req_s;
      end else if (core_req_s) begin
         // A combined load/store request is treated as a store.
         mem_re_o     = core_re_i & !core_we_i;
         mem_we_o     = core_we_i;
      end else begin
         mem_re_o     = 1'b0;
         mem_we_o     = 1'b0;
      end
   end

   // Starvation counter: counts denied cycles of a pending aux request.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end else if (aux_win_s || !aux_valid_i) begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end else begin
         starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end
   end

   // Aux read response capture, one cycle after the transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         aux_rvalid_r <= 1'b0;
         aux_rdata_r  <= 32'd0;
      end else begin
         aux_rvalid_r <= aux_rd_xfer_s;
         if (aux_rd_xfer_s) begin
            aux_rdata_r <= mem_rdata_i;
         end else begin
            aux_rdata_r <= aux_rdata_r;
         end
      end
   end

   // A response pulse landing in a reset cycle is suppressed.
   assign aux_rvalid_o = aux_rvalid_r & !rst;
   assign aux_rdata_o  = aux_rdata_r;
   assign core_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter with a behavioural data memory
// and a scoreboard queue of expected aux read responses.
module tb_dmem_port_arbiter;
   import dmem_pkg::*;

   logic             clk;
   logic             rst;
   logic             core_re, core_we;
   data_size_e       core_size;
   logic [9:0]       core_addr;
   logic [31:0]      core_wdata, core_rdata;
   logic             core_stall;
   logic             aux_valid, aux_we;
   data_size_e       aux_size;
   logic [9:0]       aux_addr;
   logic [31:0]      aux_wdata;
   logic             aux_ready, aux_rvalid;
   logic [31:0]      aux_rdata;
   logic [9:0]       mem_addr;
   logic             mem_re, mem_we;
   data_size_e       mem_size;
   logic [31:0]      mem_wdata, mem_rdata;

   logic [31:0]      mem [0:255];
   logic [31:0]      sb_q [$];
   logic [31:0]      exp_d;
   int               n_checks;
   int               n_pass;

   dmem_port_arbiter #(.ADDR_WIDTH(10), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .core_re_i(core_re), .core_we_i(core_we), .core_size_i(core_size),
      .core_addr_i(core_addr), .core_wdata_i(core_wdata), .core_rdata_o(core_rdata),
      .core_stall_o(core_stall),
      .aux_valid_i(aux_valid), .aux_we_i(aux_we), .aux_size_i(aux_size),
      .aux_addr_i(aux_addr), .aux_wdata_i(aux_wdata), .aux_ready_o(aux_ready),
      .aux_rvalid_o(aux_rvalid), .aux_rdata_o(aux_rdata),
      .mem_addr_o(mem_addr), .mem_re_o(mem_re), .mem_we_o(mem_we),
      .mem_size_o(mem_size), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Word-wide data memory: combinational read, write on the rising edge.
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; aux_valid = 1'b1; aux_we = 1'b0; aux_addr = 10'h010; core_we = 1'b1;
      tick();
      @(negedge clk);
      n_checks++; if (aux_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", aux_ready); else n_pass++;
      n_checks++; if (core_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", core_stall); else n_pass++;
      n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else n_pass++;
      n_checks++; if (mem_re !== 1'b0) $display("FAIL rst_mem_re: got %b want 0", mem_re); else n_pass++;
      n_checks++; if (aux_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", aux_rvalid); else n_pass++;
      n_checks++; if (aux_rdata !== 32'd0) $display("FAIL rst_rdata: got %h want 0", aux_rdata); else n_pass++;
      n_checks++; if (dut.starve_cnt_r !== 3'd0) $display("FAIL rst_cnt: got %0d want 0", dut.starve_cnt_r); else n_pass++;
      tick();
      rst = 1'b0; aux_valid = 1'b0; core_we = 1'b0;
      @(negedge clk);
      n_checks++; if (aux_rvalid !== 1'b0) $display("FAIL rst_no_resp: got %b want 0", aux_rvalid); else n_pass++;
      tick();
   endtask

   task automatic test_idle_read();
      aux_valid = 1'b1; aux_we = 1'b0; aux_addr = 10'h010;
      sb_q.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      n_checks++; if (aux_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", aux_ready); else n_pass++;
      n_checks++; if (core_stall !== 1'b0) $display("FAIL idle_stall: got %b want 0", core_stall); else n_pass++;
      n_checks++; if (mem_re !== 1'b1 || mem_addr !== 10'h010) $display("FAIL idle_mem: got re=%b addr=%h want re=1 addr=010", mem_re, mem_addr); else n_pass++;
      tick();
      aux_valid = 1'b0;
      @(negedge clk);
      exp_d = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hFFFF_FFFF;
      n_checks++; if (aux_rvalid !== 1'b1) $display("FAIL idle_rvalid: got %b want 1", aux_rvalid); else n_pass++;
      n_checks++; if (aux_rdata !== exp_d) $display("FAIL idle_rdata: got %h want %h", aux_rdata, exp_d); else n_pass++;
      tick();
      @(negedge clk);
      n_checks++; if (aux_rvalid !== 1'b0) $display("FAIL idle_pulse: got %b want 0", aux_rvalid); else n_pass++;
      tick();
   endtask

   task automatic test_starvation();
      int  model_cnt;
      logic exp_win, prev_win;
      model_cnt = 0; prev_win = 1'b0;
      core_re = 1'b1; core_addr = 10'h100;
      aux_valid = 1'b1; aux_we = 1'b0; aux_addr = 10'h040;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         exp_win = (model_cnt == 4);
         n_checks++; if (dut.starve_cnt_r !== 3'(model_cnt)) $display("FAIL starve_cnt c%0d: got %0d want %0d", c, dut.starve_cnt_r, model_cnt); else n_pass++;
         n_checks++; if (aux_ready !== exp_win) $display("FAIL starve_ready c%0d: got %b want %b", c, aux_ready, exp_win); else n_pass++;
         n_checks++; if (core_stall !== exp_win) $display("FAIL starve_stall c%0d: got %b want %b", c, core_stall, exp_win); else n_pass++;
         n_checks++; if (aux_rvalid !== prev_win) $display("FAIL starve_rvalid c%0d: got %b want %b", c, aux_rvalid, prev_win); else n_pass++;
         if (prev_win) begin
            exp_d = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hFFFF_FFFF;
            n_checks++; if (aux_rdata !== exp_d) $display("FAIL starve_rdata c%0d: got %h want %h", c, aux_rdata, exp_d); else n_pass++;
         end
         if (!exp_win) begin
            n_checks++; if (core_rdata !== 32'h1111_0100) $display("FAIL starve_core_rdata c%0d: got %h want 11110100", c, core_rdata); else n_pass++;
         end else begin
            sb_q.push_back(32'hA5A5_0040);
         end
         model_cnt = exp_win ? 0 : model_cnt + 1;
         prev_win  = exp_win;
         tick();
      end
      core_re = 1'b0; aux_valid = 1'b0;
      tick();
   endtask

   task automatic test_collision();
      mem[8'h08] = 32'd0;
      core_we = 1'b1; core_addr = 10'h020; core_wdata = 32'h1234_5678;
      aux_valid = 1'b1; aux_we = 1'b0; aux_addr = 10'h020;
      @(negedge clk);
      n_checks++; if (aux_ready !== 1'b0 || core_stall !== 1'b0) $display("FAIL coll_grant: got ready=%b stall=%b want 0/0", aux_ready, core_stall); else n_pass++;
      n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678) $display("FAIL coll_write: got we=%b wdata=%h want 1/12345678", mem_we, mem_wdata); else n_pass++;
      tick();
      core_we = 1'b0;
      @(negedge clk);
      n_checks++; if (aux_ready !== 1'b1) $display("FAIL coll_aux_ready: got %b want 1", aux_ready); else n_pass++;
      sb_q.push_back(32'h1234_5678);
      tick();
      aux_valid = 1'b0;
      @(negedge clk);
      exp_d = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hFFFF_FFFF;
      n_checks++; if (aux_rvalid !== 1'b1) $display("FAIL coll_rvalid: got %b want 1", aux_rvalid); else n_pass++;
      n_checks++; if (aux_rdata !== exp_d) $display("FAIL coll_rdata: got %h want %h", aux_rdata, exp_d); else n_pass++;
      tick();
   endtask

   task automatic test_re_we();
      core_re = 1'b1; core_we = 1'b1; core_addr = 10'h030; core_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      n_checks++; if (mem_we !== 1'b1) $display("FAIL rewe_we: got %b want 1", mem_we); else n_pass++;
      n_checks++; if (mem_re !== 1'b0) $display("FAIL rewe_re: got %b want 0", mem_re); else n_pass++;
      tick();
      core_re = 1'b0; core_we = 1'b0;
      @(negedge clk);
      n_checks++; if (mem[8'h0C] !== 32'hCAFE_F00D) $display("FAIL rewe_mem: got %h want cafef00d", mem[8'h0C]); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid_read();
      aux_valid = 1'b1; aux_we = 1'b0; aux_addr = 10'h010;
      @(negedge clk);
      n_checks++; if (aux_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", aux_ready); else n_pass++;
      tick();
      rst = 1'b1; aux_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (aux_rvalid !== 1'b0) $display("FAIL midrst_suppress: got %b want 0", aux_rvalid); else n_pass++;
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (aux_rvalid !== 1'b0) $display("FAIL midrst_rvalid: got %b want 0", aux_rvalid); else n_pass++;
      n_checks++; if (aux_rdata !== 32'd0) $display("FAIL midrst_rdata: got %h want 0", aux_rdata); else n_pass++;
      n_checks++; if (dut.starve_cnt_r !== 3'd0) $display("FAIL midrst_cnt: got %0d want 0", dut.starve_cnt_r); else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         aux_valid = 1'b1; aux_we = 1'b1; aux_addr = 10'(4 * i); aux_wdata = 32'hB000_0000 + 32'(i);
         @(negedge clk);
         n_checks++; if (aux_ready !== 1'b1 || mem_we !== 1'b1) $display("FAIL b2b_wr%0d: got ready=%b we=%b want 1/1", i, aux_ready, mem_we); else n_pass++;
         n_checks++; if (aux_rvalid !== 1'b0) $display("FAIL b2b_wr_rvalid%0d: got %b want 0", i, aux_rvalid); else n_pass++;
         tick();
      end
      aux_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (aux_rvalid !== 1'b0) $display("FAIL b2b_wr_tail: got %b want 0", aux_rvalid); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (mem[i] !== 32'hB000_0000 + 32'(i)) $display("FAIL b2b_mem%0d: got %h want %h", i, mem[i], 32'hB000_0000 + 32'(i)); else n_pass++;
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         aux_valid = (i < 2); aux_we = 1'b0; aux_addr = 10'(4 * i);
         @(negedge clk);
         if (i > 0) begin
            exp_d = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hFFFF_FFFF;
            n_checks++; if (aux_rvalid !== 1'b1 || aux_rdata !== exp_d) $display("FAIL b2b_rd%0d: got v=%b d=%h want 1/%h", i, aux_rvalid, aux_rdata, exp_d); else n_pass++;
         end
         if (i < 2) begin
            n_checks++; if (aux_ready !== 1'b1) $display("FAIL b2b_rd_ready%0d: got %b want 1", i, aux_ready); else n_pass++;
            sb_q.push_back(32'hB000_0000 + 32'(i));
         end
         tick();
      end
      @(negedge clk);
      n_checks++; if (aux_rvalid !== 1'b0) $display("FAIL b2b_rd_tail: got %b want 0", aux_rvalid); else n_pass++;
      tick();
   endtask

   task automatic test_drop();
      core_re = 1'b1; core_addr = 10'h100; aux_valid = 1'b1; aux_we = 1'b0; aux_addr = 10'h040;
      tick();
      tick();
      @(negedge clk);
      n_checks++; if (dut.starve_cnt_r !== 3'd2) $display("FAIL drop_cnt_pre: got %0d want 2", dut.starve_cnt_r); else n_pass++;
      tick();
      aux_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (aux_ready !== 1'b0 || core_stall !== 1'b0) $display("FAIL drop_grant: got ready=%b stall=%b want 0/0", aux_ready, core_stall); else n_pass++;
      tick();
      @(negedge clk);
      n_checks++; if (dut.starve_cnt_r !== 3'd0) $display("FAIL drop_cnt: got %0d want 0", dut.starve_cnt_r); else n_pass++;
      core_re = 1'b0;
      tick();
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      rst = 1'b1;
      core_re = 1'b0; core_we = 1'b0; core_size = SIZE_WORD; core_addr = 10'h000; core_wdata = 32'd0;
      aux_valid = 1'b0; aux_we = 1'b0; aux_size = SIZE_WORD; aux_addr = 10'h000; aux_wdata = 32'd0;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      mem[8'h04] = 32'hDEAD_BEEF;
      mem[8'h10] = 32'hA5A5_0040;
      mem[8'h40] = 32'h1111_0100;
      test_reset();
      test_idle_read();
      test_starvation();
      test_collision();
      test_re_we();
      test_reset_mid_read();
      test_back_to_back();
      test_drop();
      n_checks++; if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d left want 0", sb_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
